// File: rtl/div16x8_seq.sv
// rtl/div16x8_seq.sv - sequential 16/8 restoring divider, one quotient bit per clock
//
// Purpose:
//   Divides a 16-bit dividend by an 8-bit divisor. The result is an 8-bit
//   quotient and an 8-bit remainder. Operands are latched when start is seen
//   in IDLE. Eight CALC cycles produce the result, which is held in DONE.
//   A zero divisor, or a quotient too wide for 8 bits, goes straight to ERR.
//   In ERR both results read 8'hFF.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_a    in   1   asynchronous active-low reset
//   dividend   in  16   numerator, sampled on the accept edge
//   divisor    in   8   denominator, sampled on the accept edge
//   start      in   1   level request, accepted only in IDLE
//   quotient   out  8   registered quotient
//   remainder  out  8   registered remainder
//   done_flag  out  1   high in DONE and ERR
//   div_zero   out  1   last accepted divisor was zero
//   overflow   out  1   last accepted quotient would not fit in 8 bits
//   state_out  out  3   IDLE=0, CALC=1, DONE=2, ERR=3

module div16x8_seq (
    input  logic        clk,
    input  logic        reset_a,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    input  logic        start,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        done_flag,
    output logic        div_zero,
    output logic        overflow,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        DONE = 3'd2,
        ERR  = 3'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  r_q, r_d;            // partial remainder
    logic [7:0]  q_q, q_d;            // dividend low byte shifting out, quotient bits shifting in
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [7:0]  quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        div_zero_q, div_zero_d;
    logic        overflow_q, overflow_d;

    // The remainder stays below the divisor, so {R, Q[7]} < 2*divisor.
    // When the trial goes negative, the 9-bit difference wraps with bit 8 set.
    // When it is non-negative, the difference is below 256, so bit 8 is clear.
    // Bit 8 therefore acts as the borrow.
    logic [8:0]  trial;
    logic [7:0]  r_next;
    logic [7:0]  q_next;

    always_comb begin
        trial  = {r_q, q_q[7]} - {1'b0, divisor_q};
        if (!trial[8]) begin
            r_next = trial[7:0];
            q_next = {q_q[6:0], 1'b1};
        end else begin
            r_next = {r_q[6:0], q_q[7]};
            q_next = {q_q[6:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    divisor_d  = divisor;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    if (divisor == 8'd0) begin
                        // A zero divisor takes priority over the overflow test.
                        div_zero_d  = 1'b1;
                        quotient_d  = 8'hFF;
                        remainder_d = 8'hFF;
                        state_d     = ERR;
                    end else if (dividend[15:8] >= divisor) begin
                        overflow_d  = 1'b1;
                        quotient_d  = 8'hFF;
                        remainder_d = 8'hFF;
                        state_d     = ERR;
                    end else begin
                        r_d     = dividend[15:8];
                        q_d     = dividend[7:0];
                        cnt_d   = 3'd0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    quotient_d  = q_next;
                    remainder_d = r_next;
                    state_d     = DONE;
                end
            end

            DONE, ERR: begin
                // Wait for start to fall, so one request runs only one operation.
                if (!start) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q     <= IDLE;
            r_q         <= 8'd0;
            q_q         <= 8'd0;
            cnt_q       <= 3'd0;
            divisor_q   <= 8'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;
    assign done_flag = (state_q == DONE) || (state_q == ERR);
    assign state_out = state_q;

endmodule

// File: tb/tb_div16x8_seq.sv
// tb/tb_div16x8_seq.sv - directed self-checking bench for div16x8_seq

module tb_div16x8_seq;

    logic        clk;
    logic        reset_a;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        start;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        done_flag;
    logic        div_zero;
    logic        overflow;
    logic [2:0]  state_out;

    int total;
    int bad;

    div16x8_seq dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .dividend  (dividend),
        .divisor   (divisor),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .done_flag (done_flag),
        .div_zero  (div_zero),
        .overflow  (overflow),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dsr;
        logic [7:0]  exp_q;
        logic [7:0]  exp_r;
        logic        exp_dz;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation with a start pulse one cycle wide.
    // Then checks latency, flags, results and the return to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int early;
        @(negedge clk);
        dividend = v.dvd;
        divisor  = v.dsr;
        start    = 1'b1;
        tick();
        start = 1'b0;
        if (v.exp_dz || v.exp_ov) begin
            chk({tag, " err_state"}, 16'(state_out), 16'd3);
            chk({tag, " err_done"},  16'(done_flag), 16'd1);
        end else begin
            chk({tag, " calc_state"}, 16'(state_out), 16'd1);
            early = 0;
            for (int i = 1; i < 8; i++) begin
                tick();
                if (done_flag || state_out != 3'd1) early++;
            end
            chk({tag, " calc_len"}, 16'(early), 16'd0);
            tick();
            chk({tag, " done_state"}, 16'(state_out), 16'd2);
            chk({tag, " done_flag"},  16'(done_flag), 16'd1);
        end
        chk({tag, " quotient"},  16'(quotient),  16'(v.exp_q));
        chk({tag, " remainder"}, 16'(remainder), 16'(v.exp_r));
        chk({tag, " div_zero"},  16'(div_zero),  16'(v.exp_dz));
        chk({tag, " overflow"},  16'(overflow),  16'(v.exp_ov));
        tick();
        chk({tag, " back_idle"}, 16'(state_out), 16'd0);
        chk({tag, " held_q"},    16'(quotient),  16'(v.exp_q));
    endtask

    initial begin
        int   cnt;
        vec_t v;
        total    = 0;
        bad      = 0;
        reset_a  = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;

        //          dividend  dsr    q      r      dz    ov
        vecs[0]  = '{16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{16'h7918, 8'h9B, 8'hC8, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{16'h0100, 8'h02, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0};
        vecs[6]  = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0};
        vecs[7]  = '{16'h0400, 8'h05, 8'hCC, 8'h04, 1'b0, 1'b0};
        vecs[8]  = '{16'h1234, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{16'hFFFF, 8'h10, 8'hFF, 8'hFF, 1'b0, 1'b1};
        vecs[10] = '{16'h0500, 8'h05, 8'hFF, 8'hFF, 1'b0, 1'b1};
        vecs[11] = '{16'hFFFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};

        // Reset state
        #12;
        chk("rst quotient",  16'(quotient),  16'd0);
        chk("rst remainder", 16'(remainder), 16'd0);
        chk("rst done",      16'(done_flag), 16'd0);
        chk("rst dz",        16'(div_zero),  16'd0);
        chk("rst ov",        16'(overflow),  16'd0);
        chk("rst state",     16'(state_out), 16'd0);
        @(negedge clk);
        reset_a = 1'b1;
        tick();
        tick();
        chk("post_rst idle", 16'(state_out), 16'd0);
        chk("post_rst done", 16'(done_flag), 16'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Hold start high through DONE, and change the operands so that a
        // re-trigger would show up.
        @(negedge clk);
        dividend = 16'h1234;
        divisor  = 8'h56;
        start    = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("hold done_state", 16'(state_out), 16'd2);
        dividend = 16'h0000;
        divisor  = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        chk("hold still_done", 16'(state_out), 16'd2);
        chk("hold done_flag",  16'(done_flag), 16'd1);
        chk("hold quotient",   16'(quotient),  16'h36);
        chk("hold remainder",  16'(remainder), 16'h10);
        start = 1'b0;
        tick();
        chk("hold release_idle", 16'(state_out), 16'd0);
        tick();
        chk("hold no_retrigger", 16'(state_out), 16'd0);
        chk("hold dz_clear",     16'(div_zero),  16'd0);

        // Toggle start during CALC.
        // Also check that old results survive until the new operation ends.
        @(negedge clk);
        dividend = 16'h03E8;
        divisor  = 8'h07;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            start = i[0];
            if (i == 4) chk("tog old_q_kept", 16'(quotient), 16'h36);
        end
        start = 1'b0;
        tick();
        chk("tog done_state", 16'(state_out), 16'd2);
        chk("tog quotient",   16'(quotient),  16'h8E);
        chk("tog remainder",  16'(remainder), 16'h06);
        tick();
        chk("tog idle", 16'(state_out), 16'd0);

        // Reset in the fourth CALC cycle.
        @(negedge clk);
        dividend = 16'h1234;
        divisor  = 8'h56;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid calc_state", 16'(state_out), 16'd1);
        reset_a = 1'b0;
        #1;
        chk("mid rst_state", 16'(state_out), 16'd0);
        chk("mid rst_q",     16'(quotient),  16'd0);
        chk("mid rst_r",     16'(remainder), 16'd0);
        chk("mid rst_done",  16'(done_flag), 16'd0);
        @(negedge clk);
        reset_a = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_flag || state_out != 3'd0) cnt++;
        end
        chk("mid no_spurious", 16'(cnt), 16'd0);
        v = vecs[0];
        run_vec(v, "mid rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
